// File: rtl/hdmi_rx_pkg.sv
// Shared definitions for the HDMI receive capture path: default widths,
// capture FSM encoding and the link-status helper.
package hdmi_rx_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 12;
  localparam int DEF_FCNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_LINK,
    ST_WAIT_VSYNC,
    ST_CAPTURE
  } cap_state_e;

  // The link counts as up only when every channel is both valid and ready.
  function automatic logic link_up(input logic [2:0] vld, input logic [2:0] rdy);
    return &{vld, rdy};
  endfunction

endpackage

// File: rtl/hdmi_capture_window_if.sv
// Pixel write port from the capture window into a downstream FIFO.
interface hdmi_capture_window_if
  import hdmi_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic [3*DATA_W-1:0] fifo_data;
  logic                fifo_wr_en;
  logic                fifo_full;

  modport master (output fifo_data, output fifo_wr_en, input fifo_full);
  modport slave  (input fifo_data, input fifo_wr_en, output fifo_full);

endinterface

// File: rtl/hdmi_sync_edge.sv
// Registered edge detector for a single timing strobe (vsync or de).
module hdmi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/hdmi_capture_window.sv
// Captures a rectangular window of decoded HDMI pixels into a FIFO, one frame
// per start request or continuously, with sticky overflow/link/truncation status.
module hdmi_capture_window
  import hdmi_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int FCNT_W = DEF_FCNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  de,
  input  logic [2:0]            chan_vld,
  input  logic [2:0]            chan_rdy,
  input  logic [DATA_W-1:0]     red,
  input  logic [DATA_W-1:0]     green,
  input  logic [DATA_W-1:0]     blue,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [CNT_W-1:0]      win_x0,
  input  logic [CNT_W-1:0]      win_y0,
  input  logic [CNT_W-1:0]      win_w,
  input  logic [CNT_W-1:0]      win_h,
  hdmi_capture_window_if.master fifo,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  link_err,
  output logic                  trunc,
  output logic [FCNT_W-1:0]     frame_count
);

  cap_state_e       state;
  logic [CNT_W-1:0] x, y, x0_q, y0_q, w_q, h_q;
  logic [CNT_W:0]   x_end, y_end, y_next;
  logic             vs_rise, de_fall, link_ok, in_win, frame_end;
  logic             unused_vs_fall, unused_de_rise, unused_hsync;

  // Line timing is derived from de alone; hsync is accepted but not needed.
  assign unused_hsync = hsync;

  hdmi_sync_edge u_vs_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (vsync),
    .rise (vs_rise),
    .fall (unused_vs_fall)
  );

  hdmi_sync_edge u_de_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (de),
    .rise (unused_de_rise),
    .fall (de_fall)
  );

  // Window limits carry one extra bit so origin + size never wraps.
  assign x_end     = {1'b0, x0_q} + {1'b0, w_q};
  assign y_end     = {1'b0, y0_q} + {1'b0, h_q};
  assign y_next    = {1'b0, y} + (CNT_W + 1)'(1);
  assign link_ok   = link_up(chan_vld, chan_rdy);
  assign in_win    = de && (x >= x0_q) && ({1'b0, x} < x_end)
                        && (y >= y0_q) && ({1'b0, y} < y_end);
  assign frame_end = de_fall && (y_next == y_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (vs_rise) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= de ? x + CNT_W'(1) : '0;
      if (de_fall) y <= y + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      // NOTE: window registers are reset as well so a stale window can never leak into a new capture.
      x0_q            <= '0;
      y0_q            <= '0;
      w_q             <= '0;
      h_q             <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      overflow        <= 1'b0;
      link_err        <= 1'b0;
      trunc           <= 1'b0;
      frame_count     <= '0;
      fifo.fifo_wr_en <= 1'b0;
      fifo.fifo_data  <= '0;
    end else begin
      frame_done      <= 1'b0;
      fifo.fifo_wr_en <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start && (win_w != '0) && (win_h != '0)) begin
            x0_q     <= win_x0;
            y0_q     <= win_y0;
            w_q      <= win_w;
            h_q      <= win_h;
            overflow <= 1'b0;
            link_err <= 1'b0;
            trunc    <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_WAIT_LINK;
          end
        end
        ST_WAIT_LINK: begin
          if (link_ok) state <= ST_WAIT_VSYNC;
        end
        ST_WAIT_VSYNC: begin
          if (!link_ok) begin
            link_err <= 1'b1;
            state    <= ST_WAIT_LINK;
          end else if (vs_rise) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (!link_ok) begin
            link_err <= 1'b1;
            state    <= ST_WAIT_LINK;
          end else if (frame_end || vs_rise) begin
            // A vsync before the last window line means the frame was cut short;
            // in continuous mode that same vsync starts the next capture.
            trunc       <= trunc | (vs_rise && !frame_end);
            frame_done  <= 1'b1;
            frame_count <= frame_count + FCNT_W'(1);
            if (!continuous) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else if (frame_end) begin
              state <= ST_WAIT_VSYNC;
            end
          end else if (in_win) begin
            if (fifo.fifo_full) begin
              overflow <= 1'b1;
            end else begin
              fifo.fifo_wr_en <= 1'b1;
              fifo.fifo_data  <= {red, green, blue};
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
